universal_shift_reg: RTL and testbench

Parametrised, clocked universal shift register: the multi-bit, edge-triggered successor to the team's single-bit latch primitives. It supports hold, parallel load and multi-step left/right shifts driven by a start/busy/done handshake. It serves as the general-purpose storage and serialisation element in the sequential-circuits library.

---
 rtl/usr_pkg.sv | 17 +
 rtl/universal_shift_reg_if.sv | 42 ++++
 rtl/usr_ctrl.sv | 99 +++++++++
 rtl/universal_shift_reg.sv | 65 ++++++
 tb/tb_universal_shift_reg.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and control FSM states.
// Rotate support is compiled in with USR_ROTATE_EN; see universal_shift_reg.sv.
package usr_pkg;

   typedef enum logic [1:0] {
      USR_HOLD = 2'b00,
      USR_SHL  = 2'b01,
      USR_SHR  = 2'b10,
      USR_LOAD = 2'b11
   } usr_mode_e;

   typedef enum logic {
      USR_IDLE  = 1'b0,
      USR_SHIFT = 1'b1
   } usr_state_e;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Command/status bundle of the universal shift register.
// The rot signal exists only when USR_ROTATE_EN is defined.
interface universal_shift_reg_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
   logic             start;
   logic [1:0]       mode;
   logic [CNT_W-1:0] amt;
   logic [WIDTH-1:0] pdata;
   logic             sin_lsb;
   logic             sin_msb;
`ifdef USR_ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic             sout_msb;
   logic             sout_lsb;
   logic             busy;
   logic             done;

`ifdef USR_ROTATE_EN
   modport master (
      output start, mode, amt, pdata, sin_lsb, sin_msb, rot,
      input  q, sout_msb, sout_lsb, busy, done
   );
   modport slave (
      input  start, mode, amt, pdata, sin_lsb, sin_msb, rot,
      output q, sout_msb, sout_lsb, busy, done
   );
`else
   modport master (
      output start, mode, amt, pdata, sin_lsb, sin_msb,
      input  q, sout_msb, sout_lsb, busy, done
   );
   modport slave (
      input  start, mode, amt, pdata, sin_lsb, sin_msb,
      output q, sout_msb, sout_lsb, busy, done
   );
`endif

endinterface

// File: rtl/usr_ctrl.sv
// Control FSM of the universal shift register: accepts commands in idle, counts shift steps,
// and produces busy, the done pulse and per-edge load/shift strobes for the datapath.
module usr_ctrl
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] amt_i,
   input  logic             rot_i,
   output logic             load_o,
   output logic             shift_o,
   output logic             left_o,
   output logic             rot_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] MaxAmt = CNT_W'(WIDTH);

   usr_state_e       state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             left_q, left_d;
   logic             rot_q, rot_d;
   logic             done_q, done_d;
   usr_mode_e        mode;
   logic [CNT_W-1:0] amt_sat;

   assign mode    = usr_mode_e'(mode_i);
   assign amt_sat = (amt_i > MaxAmt) ? MaxAmt : amt_i;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      left_d  = left_q;
      rot_d   = rot_q;
      done_d  = 1'b0;
      load_o  = 1'b0;
      shift_o = 1'b0;
      unique case (state_q)
         USR_IDLE: begin
            if (start_i) begin
               unique case (mode)
                  USR_LOAD: begin
                     load_o = 1'b1;
                     done_d = 1'b1;
                  end
                  USR_HOLD: done_d = 1'b1;
                  USR_SHL, USR_SHR: begin
                     if (amt_sat == '0) begin
                        done_d = 1'b1;
                     end else begin
                        // Command edge only arms the counter; shifting starts next edge.
                        left_d  = (mode == USR_SHL);
                        rot_d   = rot_i;
                        rem_d   = amt_sat;
                        state_d = USR_SHIFT;
                     end
                  end
               endcase
            end
         end
         USR_SHIFT: begin
            shift_o = 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
               state_d = USR_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= USR_IDLE;
         rem_q   <= '0;
         left_q  <= 1'b0;
         rot_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         left_q  <= left_d;
         rot_q   <= rot_d;
         done_q  <= done_d;
      end
   end

   assign left_o = left_q;
   assign rot_o  = rot_q;
   assign busy_o = (state_q == USR_SHIFT);
   assign done_o = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register top: q register and shift muxing around the usr_ctrl FSM.
// Define USR_ROTATE_EN to add the rot input (rotate instead of serial fill).
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   universal_shift_reg_if.slave bus
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             load, shift, left, rot_q, rot_in;
   logic             lsb_in, msb_in;

`ifdef USR_ROTATE_EN
   assign rot_in = bus.rot;
`else
   assign rot_in = 1'b0;
`endif

   usr_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (bus.start),
      .mode_i  (bus.mode),
      .amt_i   (bus.amt),
      .rot_i   (rot_in),
      .load_o  (load),
      .shift_o (shift),
      .left_o  (left),
      .rot_o   (rot_q),
      .busy_o  (bus.busy),
      .done_o  (bus.done)
   );

   always_comb begin
      lsb_in = rot_q ? q_q[WIDTH-1] : bus.sin_lsb;
      msb_in = rot_q ? q_q[0] : bus.sin_msb;
      q_d    = q_q;
      if (load) begin
         q_d = bus.pdata;
      end else if (shift) begin
         q_d = left ? {q_q[WIDTH-2:0], lsb_in} : {msb_in, q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.sout_msb = q_q[WIDTH-1];
   assign bus.sout_lsb = q_q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: vector table plus hand-written corner sequences.
// Rotate vectors run only when USR_ROTATE_EN is defined.
module tb_universal_shift_reg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   universal_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   universal_shift_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0] mode;
      logic [3:0] amt;
      logic [7:0] pdata;
      logic       sl;
      logic       sm;
      logic [7:0] eq;
      int         lat;
      int         nbusy;
   } vec_t;

   typedef struct {
      logic [7:0] q;
      int         lat;
      int         nbusy;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[11];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge where done is seen (or the budget expires).
   task automatic run_op(input string nm, input logic [1:0] mode, input logic [3:0] amt,
                         input logic [7:0] pdata, input logic sl, input logic sm, input logic r,
                         input logic [7:0] eq, input int lat, input int nbusy, input int intrude);
      exp_t e;
      int   edges;
      int   nb;
      sb.push_back('{q: eq, lat: lat, nbusy: nbusy});
      bus.start   = 1'b1;
      bus.mode    = mode;
      bus.amt     = amt;
      bus.pdata   = pdata;
      bus.sin_lsb = sl;
      bus.sin_msb = sm;
`ifdef USR_ROTATE_EN
      bus.rot     = r;
`endif
      tick();
      edges     = 1;
      nb        = 0;
      bus.start = 1'b0;
      while (!bus.done && edges < 40) begin
         if (bus.busy) nb++;
         if (edges == intrude) begin
            bus.start = 1'b1;
            bus.mode  = 2'b11;
            bus.pdata = 8'h11;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         edges++;
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      check({nm, " latency"}, edges, e.lat);
      check({nm, " busy cycles"}, nb, e.nbusy);
      check({nm, " q"}, bus.q, e.q);
      check({nm, " busy with done"}, bus.busy, 1'b0);
      check({nm, " sout_msb"}, bus.sout_msb, e.q[7]);
      check({nm, " sout_lsb"}, bus.sout_lsb, e.q[0]);
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.mode    = 2'b00;
      bus.amt     = '0;
      bus.pdata   = '0;
      bus.sin_lsb = 1'b0;
      bus.sin_msb = 1'b0;
`ifdef USR_ROTATE_EN
      bus.rot     = 1'b0;
`endif
      //          mode   amt    pdata  sl    sm    eq     lat nbusy
      vecs[0]  = '{2'b11, 4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1, 0};
      vecs[1]  = '{2'b11, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1, 0};
      vecs[2]  = '{2'b01, 4'd3,  8'h00, 1'b1, 1'b0, 8'h0F, 4, 3};
      vecs[3]  = '{2'b00, 4'd0,  8'hFF, 1'b0, 1'b0, 8'h0F, 1, 0};
      vecs[4]  = '{2'b11, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C, 1, 0};
      vecs[5]  = '{2'b10, 4'd0,  8'h00, 1'b0, 1'b1, 8'h3C, 1, 0};
      vecs[6]  = '{2'b10, 4'd2,  8'h00, 1'b0, 1'b1, 8'hCF, 3, 2};
      vecs[7]  = '{2'b01, 4'd1,  8'h00, 1'b0, 1'b1, 8'h9E, 2, 1};
      vecs[8]  = '{2'b01, 4'd8,  8'h00, 1'b1, 1'b0, 8'hFF, 9, 8};
      vecs[9]  = '{2'b10, 4'd15, 8'h00, 1'b1, 1'b0, 8'h00, 9, 8};
      vecs[10] = '{2'b01, 4'd0,  8'h00, 1'b1, 1'b1, 8'h00, 1, 0};

      // Reset, then idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset q", bus.q, 8'h00);
      check("reset busy", bus.busy, 1'b0);
      check("reset done", bus.done, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("idle q %0d", i), bus.q, 8'h00);
      end
      check("idle done", bus.done, 1'b0);

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].amt, vecs[i].pdata, vecs[i].sl,
                vecs[i].sm, 1'b0, vecs[i].eq, vecs[i].lat, vecs[i].nbusy, 0);
         tick();
         check($sformatf("vec%0d done pulse", i), bus.done, 1'b0);
         check($sformatf("vec%0d q hold", i), bus.q, vecs[i].eq);
      end

      // Saturated shift with a LOAD attempt while busy
      run_op("load ff", 2'b11, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1, 0, 0);
      run_op("shr9 busy start", 2'b10, 4'd9, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 9, 8, 3);
      tick();
      check("busy start ignored q", bus.q, 8'h00);
      check("busy start ignored done", bus.done, 1'b0);

      // New start accepted in the done cycle
      run_op("load 5a", 2'b11, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1, 0, 0);
      bus.start   = 1'b1;
      bus.mode    = 2'b01;
      bus.amt     = 4'd1;
      bus.sin_lsb = 1'b1;
      tick();
      bus.start = 1'b0;
      check("b2b busy", bus.busy, 1'b1);
      tick();
      check("b2b done", bus.done, 1'b1);
      check("b2b q", bus.q, 8'hB5);

      // Reset in the middle of a shift
      run_op("load f0", 2'b11, 4'd0, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 1, 0, 0);
      bus.start   = 1'b1;
      bus.mode    = 2'b10;
      bus.amt     = 4'd5;
      bus.sin_msb = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("midshift q", bus.q, 8'h3C);
      check("midshift busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      tick();
      check("midreset q", bus.q, 8'h00);
      check("midreset busy", bus.busy, 1'b0);
      check("midreset done", bus.done, 1'b0);
      rst_n = 1'b1;
      tick();
      check("postreset busy", bus.busy, 1'b0);
      check("postreset done", bus.done, 1'b0);
      check("postreset q", bus.q, 8'h00);

`ifdef USR_ROTATE_EN
      run_op("rot load a", 2'b11, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1, 0, 0);
      run_op("rot shl", 2'b01, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 2, 1, 0);
      run_op("rot load b", 2'b11, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1, 0, 0);
      run_op("rot shr", 2'b10, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0, 2, 1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
